// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter sharing one slave among N masters
// Grants one master per transaction, forwards its fields, and aborts stalls after TIMEOUT cycles.
module bus_arbiter #(
  parameter int N_MASTERS  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]       m_address,
  input  logic [N_MASTERS-1:0]                  m_read,
  input  logic [N_MASTERS-1:0]                  m_write,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]       m_data_wr,
  input  logic [N_MASTERS*(DATA_WIDTH/8)-1:0]   m_mask,
  output logic [N_MASTERS-1:0]                  m_stall,
  output logic [DATA_WIDTH-1:0]                 m_data_rd,
  output logic [DATA_WIDTH-1:0]                 m_data_rd_2,
  output logic [ADDR_WIDTH-1:0]                 s_address,
  output logic                                  s_read,
  output logic                                  s_write,
  output logic [DATA_WIDTH-1:0]                 s_data_wr,
  output logic [DATA_WIDTH/8-1:0]               s_mask,
  input  logic                                  s_stall,
  input  logic [DATA_WIDTH-1:0]                 s_data_rd,
  input  logic [DATA_WIDTH-1:0]                 s_data_rd_2,
  output logic [N_MASTERS-1:0]                  grant,
  output logic                                  err
);

  localparam int IW = $clog2(N_MASTERS);
  localparam int MW = DATA_WIDTH / 8;
  localparam int CW = 16;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state;
  logic [IW-1:0]         gidx;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         winner;
  logic [IW-1:0]         next_ptr;
  logic [CW-1:0]         cnt;
  logic [N_MASTERS-1:0]  req;
  logic                  any_req;
  logic                  busy;
  logic                  g_req;
  logic                  timeout;

  assign req      = m_read | m_write;
  assign busy     = (state == BUSY);
  assign g_req    = req[gidx];
  assign timeout  = busy && g_req && s_stall && (cnt == CW'(TIMEOUT - 1));
  assign next_ptr = (gidx == IW'(N_MASTERS - 1)) ? '0 : gidx + 1'b1;

  // Scan downward so the requester closest above ptr is the last (winning) assignment.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_MASTERS]) begin
        winner  = IW'((int'(ptr) + k) % N_MASTERS);
        any_req = 1'b1;
      end
    end
  end

  assign s_address = m_address[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_data_wr = m_data_wr[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
  assign s_mask    = m_mask[int'(gidx)*MW +: MW];
  assign s_read    = busy & m_read[gidx];
  assign s_write   = busy & m_write[gidx];

  always_comb begin
    m_stall = req;
    if (busy) begin
      m_stall[gidx] = s_stall & ~timeout;
    end
  end

  assign m_data_rd   = timeout ? '1 : s_data_rd;
  assign m_data_rd_2 = timeout ? '1 : s_data_rd_2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      ptr   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      err <= timeout;
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= BUSY;
            gidx  <= winner;
            grant <= N_MASTERS'(1) << winner;
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (!g_req) begin
            state <= IDLE;
            grant <= '0;
          end else if (!s_stall || timeout) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= next_ptr;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed and randomized checks of bus_arbiter against a transaction-level model
module tb_bus_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int MW = 4;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N*AW-1:0] m_address;
  logic [N-1:0]    rd, wr;
  logic [N*DW-1:0] m_data_wr;
  logic [N*MW-1:0] m_mask;
  logic [N-1:0]    m_stall;
  logic [DW-1:0]   m_data_rd, m_data_rd_2;
  logic [AW-1:0]   s_address;
  logic            s_read, s_write;
  logic [DW-1:0]   s_data_wr;
  logic [MW-1:0]   s_mask;
  logic            s_stall;
  logic [DW-1:0]   s_data_rd, s_data_rd_2;
  logic [N-1:0]    grant;
  logic            err;

  logic [AW-1:0] addr [N];
  logic [DW-1:0] wd   [N];
  logic [MW-1:0] mk   [N];

  always_comb begin
    m_address = '0;
    m_data_wr = '0;
    m_mask    = '0;
    for (int i = 0; i < N; i++) begin
      m_address[i*AW +: AW] = addr[i];
      m_data_wr[i*DW +: DW] = wd[i];
      m_mask[i*MW +: MW]    = mk[i];
    end
  end

  bus_arbiter #(.N_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_address(m_address), .m_read(rd), .m_write(wr),
    .m_data_wr(m_data_wr), .m_mask(m_mask), .m_stall(m_stall),
    .m_data_rd(m_data_rd), .m_data_rd_2(m_data_rd_2),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_data_wr(s_data_wr), .s_mask(s_mask), .s_stall(s_stall),
    .s_data_rd(s_data_rd), .s_data_rd_2(s_data_rd_2),
    .grant(grant), .err(err)
  );

  int vectors = 0;
  int miscompares = 0;

  // Transaction-level model: current owner (-1 = none), next search start, stalls seen, pending err.
  int owner = -1;
  int rr = 0;
  int stalls = 0;
  bit err_q = 1'b0;
  logic [N-1:0] exp_stall, last_req;
  logic [N-1:0] last_grant, last_mstall;
  logic [DW-1:0] last_rd;
  logic last_err, last_swrite;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [N-1:0] r;
    logic [N-1:0] eg;
    bit to;
    @(negedge clk);
    r  = rd | wr;
    to = 1'b0;
    eg = '0;
    exp_stall = r;
    if (owner >= 0) begin
      eg[owner] = 1'b1;
      to = r[owner] && s_stall && (stalls + 1 == TO);
      exp_stall[owner] = s_stall && !to;
    end
    chk("grant", grant, eg);
    chk("m_stall", m_stall, exp_stall);
    chk("err", err, err_q);
    chk("m_data_rd", m_data_rd, to ? {DW{1'b1}} : s_data_rd);
    chk("m_data_rd_2", m_data_rd_2, to ? {DW{1'b1}} : s_data_rd_2);
    if (owner >= 0) begin
      chk("s_read", s_read, rd[owner]);
      chk("s_write", s_write, wr[owner]);
      chk("s_address", s_address, addr[owner]);
      chk("s_data_wr", s_data_wr, wd[owner]);
      chk("s_mask", s_mask, mk[owner]);
    end else begin
      chk("s_read_idle", s_read, 1'b0);
      chk("s_write_idle", s_write, 1'b0);
    end
    last_grant  = grant;
    last_mstall = m_stall;
    last_rd     = m_data_rd;
    last_err    = err;
    last_swrite = s_write;
    last_req    = r;
    @(posedge clk);
    err_q = to;
    if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (r[(rr + k) % N]) begin
          owner  = (rr + k) % N;
          stalls = 0;
          break;
        end
      end
    end else if (!r[owner]) begin
      owner = -1;
    end else if (!s_stall || to) begin
      rr    = (owner + 1) % N;
      owner = -1;
    end else begin
      stalls++;
    end
    #1;
  endtask

  task automatic drive_rand(input int bias);
    for (int i = 0; i < N; i++) begin
      if (!(rd[i] | wr[i]) || (last_req[i] && !exp_stall[i])) begin
        rd[i] = 1'b0;
        wr[i] = 1'b0;
        if ($urandom_range(2) == 0) begin
          if ($urandom_range(1) == 0) rd[i] = 1'b1;
          else wr[i] = 1'b1;
          addr[i] = AW'($urandom);
          wd[i]   = $urandom;
          mk[i]   = MW'($urandom);
        end
      end else if (owner == i && $urandom_range(19) == 0) begin
        rd[i] = 1'b0;
        wr[i] = 1'b0;
      end
    end
    s_stall     = ($urandom_range(99) < bias);
    s_data_rd   = $urandom;
    s_data_rd_2 = $urandom;
  endtask

  int seq [9] = '{1, 0, 2, 0, 4, 0, 8, 0, 1};
  int biases [4] = '{0, 30, 70, 100};

  initial begin
    rst_n = 1'b0;
    rd = '0;
    wr = '0;
    s_stall = 1'b0;
    s_data_rd = 32'h1234_5678;
    s_data_rd_2 = 32'h9abc_def0;
    for (int i = 0; i < N; i++) begin
      addr[i] = AW'(16'h1000 + i);
      wd[i]   = 32'hA000_0000 + i;
      mk[i]   = MW'(i + 1);
    end
    #12;
    chk("reset_grant", grant, 4'b0000);
    chk("reset_s_read", s_read, 1'b0);
    chk("reset_s_write", s_write, 1'b0);
    chk("reset_err", err, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All four masters request continuously with no slave stall.
    rd = 4'hF;
    step();
    for (int k = 0; k < 9; k++) begin
      step();
      chk("rr_seq", last_grant, seq[k]);
    end

    // M1 granted and stalled three cycles while M0 waits.
    rd = 4'b0011;
    s_stall = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_m1", last_mstall, 4'b0011);
    end
    s_stall = 1'b0;
    step();
    chk("release_m1", last_mstall, 4'b0001);

    // M0 stuck on a stalled slave until the timeout fires.
    rd = 4'b0001;
    s_stall = 1'b1;
    step();
    for (int k = 0; k < 3; k++) step();
    step();
    chk("to_mstall", last_mstall, 4'b0000);
    chk("to_data", last_rd, 32'hFFFF_FFFF);
    rd = 4'b0000;
    step();
    chk("to_err", last_err, 1'b1);
    chk("to_idle", last_grant, 4'b0000);
    step();
    chk("to_err_clear", last_err, 1'b0);

    // Granted M2 withdraws its write mid-transaction; ptr must not move.
    wr = 4'b0100;
    step();
    step();
    wr = 4'b0000;
    step();
    chk("drop_swrite", last_swrite, 1'b0);
    chk("drop_grant_held", last_grant, 4'b0100);
    wr = 4'b0110;
    step();
    chk("drop_idle", last_grant, 4'b0000);
    step();
    chk("drop_ptr_kept", last_grant, 4'b0010);

    for (int b = 0; b < 12; b++) begin
      for (int c = 0; c < 200; c++) begin
        drive_rand(biases[b % 4]);
        step();
      end
    end

    // Asynchronous reset in the middle of a stalled transaction.
    rd = '0;
    wr = '0;
    step();
    step();
    rd = 4'b0001;
    s_stall = 1'b1;
    step();
    chk("pre_reset_grant", grant, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", grant, 4'b0000);
    chk("async_s_read", s_read, 1'b0);
    chk("async_err", err, 1'b0);
    owner = -1;
    rr = 0;
    stalls = 0;
    err_q = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    s_stall = 1'b0;
    rd = 4'b1001;
    step();
    step();
    chk("post_reset_grant", last_grant, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
